// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle combinational ops plus a sequential
// MULT/MULTU/DIV/DIVU unit writing HI/LO behind a start/busy/done handshake.
module alu_muldiv #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  input  logic             start,
  output logic [WIDTH-1:0] res,
  output logic             isZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int SAW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // ---------------- combinational ALU ----------------
  logic [SAW-1:0] sa;
  assign sa = a[SAW-1:0];

  always_comb begin
    res = '0;
    case (func)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd5:    res = b << LUI_SHIFT;
      4'd6:    res = a ^ b;
      4'd7:    res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd8:    res = b << sa;
      4'd9:    res = b >> sa;
      4'd10:   res = $signed(b) >>> sa;
      4'd11:   res = ~(a | b);
      default: res = '0;
    endcase
  end

  assign isZero = (res == '0);

  // ---------------- mul/div sequencer ----------------
  // Handshake: start is taken only in IDLE with func 12..15; busy is high
  // from that edge until the edge that writes hi/lo, where done pulses for
  // one cycle. start seen while busy is dropped.
  state_t             state_q, state_d;
  logic [SAW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // mul: {upper, multiplier}; div: {rem, dividend}
  logic [WIDTH-1:0]   opb_q, opb_d;    // |b|: multiplicand or divisor
  logic [WIDTH-1:0]   a_q, a_d;        // raw dividend for the divide-by-zero result
  logic               div_q, div_d;
  logic               negr_q, negr_d;  // product/quotient must be negated
  logic               negm_q, negm_d;  // remainder must be negated
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_md, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, trial, diff;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   rem_new, quo, rem;

  assign is_md     = func[3] & func[2];
  assign signed_op = is_md & ~func[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? ('0 - a) : a;
  assign b_mag     = b_neg ? ('0 - b) : b;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Partial remainder stays below the divisor, so trial and diff fit WIDTH+1 bits.
  assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = trial - {1'b0, opb_q};
  assign ge       = (trial >= {1'b0, opb_q});
  assign rem_new  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], ge};

  assign prod = negr_q ? ('0 - acc_q) : acc_q;
  assign quo  = negr_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem  = negm_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    a_d     = a_q;
    div_d   = div_q;
    negr_d  = negr_q;
    negm_d  = negm_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_md) begin
          state_d = S_RUN;
          cnt_d   = SAW'(WIDTH-1);
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          opb_d   = b_mag;
          a_d     = a;
          div_d   = func[1];
          negr_d  = a_neg ^ b_neg;
          negm_d  = a_neg;
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          {hi_d, lo_d} = prod;
        end else if (opb_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      negr_q  <= 1'b0;
      negm_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      a_q     <= a_d;
      div_q   <= div_d;
      negr_q  <= negr_d;
      negm_q  <= negm_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: combinational op vectors plus a scoreboard of
// expected {hi,lo} results popped on every done pulse.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic [3:0]   func;
  logic         start;
  logic [W-1:0] res, hi, lo;
  logic         isZero, busy, done;

  logic [2*W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  alu_muldiv #(.WIDTH(W), .LUI_SHIFT(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .func(func), .start(start),
    .res(res), .isZero(isZero), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [W-1:0] alu_model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    case (f)
      4'd0:    r = x + y;
      4'd1:    r = x - y;
      4'd2:    r = x & y;
      4'd3:    r = x | y;
      4'd4:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd5:    r = {y[15:0], 16'h0};
      4'd6:    r = x ^ y;
      4'd7:    r = (x < y) ? 32'd1 : 32'd0;
      4'd8:    r = y << x[4:0];
      4'd9:    r = y >> x[4:0];
      4'd10:   r = $signed(y) >>> x[4:0];
      4'd11:   r = ~(x | y);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [2*W-1:0] md_model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] ux, uy, p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (f)
      4'd12: begin
        q = sx * sy;
        p = q;
      end
      4'd13: p = ux * uy;
      4'd14: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("done_without_op", 64'(exp_q.size()), 64'd1);
      else check("hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic comb_chk(input string tag, input logic [3:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_res);
    func = f;
    a    = x;
    b    = y;
    #1;
    check(tag, 64'(res), 64'(exp_res));
    check({tag, "_zero"}, 64'(isZero), 64'(exp_res == 0));
  endtask

  // Launch one mul/div op and wait for done; optionally pokes a foreign start mid-flight.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int poke_at);
    int busy_cnt;
    int lat;
    bit seen;
    @(negedge clk);
    func  = f;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(md_model(f, x, y));
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    lat      = 0;
    seen     = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        seen = 1;
        lat  = i + 1;
      end else begin
        if (poke_at > 0 && i == poke_at) begin
          func  = 4'd12;
          a     = $urandom;
          b     = $urandom;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(W + 2));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    func  = '0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    comb_chk("sub_eq", 4'd1, 32'd5, 32'd5, 32'd0);
    comb_chk("sra", 4'd10, 32'd4, 32'h8000_0000, 32'hF800_0000);
    comb_chk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
    comb_chk("slt_neg", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1);
    comb_chk("sltu_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0);
    comb_chk("lui", 4'd5, 32'd0, 32'h0000_1234, 32'h1234_0000);
    comb_chk("nor", 4'd11, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00);
    comb_chk("md_func_res", 4'd13, 32'd3, 32'd4, 32'd0);
    for (int i = 0; i < 24; i++) begin
      logic [3:0]   f;
      logic [W-1:0] x, y;
      f = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      comb_chk("rand_alu", f, x, y, alu_model(f, x, y));
    end

    run_op("mult_neg", 4'd12, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6);
    check("multu_max_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    repeat (40) @(negedge clk);
    run_op("div_neg", 4'd14, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 4'd15, 32'd7, 32'd0, 0);
    check("divu_zero_val", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_val", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("div_zero_s", 4'd14, 32'hFFFF_FFF0, 32'd0, 0);
    check("div_zero_s_val", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      logic [3:0]   f;
      logic [W-1:0] x, y;
      f = 4'($urandom_range(12, 15));
      x = $urandom;
      y = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) y = -y;
      run_op("rand_md", f, x, y, 0);
    end

    // Reset while a DIVU is in its tenth RUN cycle.
    run_op("pre_rst", 4'd13, 32'd1000, 32'd1000, 0);
    @(negedge clk);
    func  = 4'd15;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("midrst_hilo_held", {hi, lo}, 64'd0);
    run_op("multu_6x7", 4'd13, 32'd6, 32'd7, 0);
    check("multu_6x7_val", {hi, lo}, 64'd42);
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor to the single-cycle CPU ALU. It keeps the same single-cycle combinational ops and adds a sequential multiply/divide unit with HI/LO result registers and a start/busy/done handshake, for MIPS MULT/MULTU/DIV/DIVU. It sits in the execute stage. The control unit stalls the pipeline while busy=1 and reads HI/LO directly for MFHI/MFLO.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, >= 8.
LUI_SHIFT, 16, left shift amount applied to b for func 5 (LUI); must be < WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt or immediate)
func  in  4  operation select
start  in  1  launch mul/div when func is 12..15
res  out  WIDTH  combinational result
isZero  out  1  res == 0 (combinational)
hi  out  WIDTH  HI register: mul upper half / div remainder
lo  out  WIDTH  LO register: mul lower half / div quotient
busy  out  1  mul/div in progress
done  out  1  one-cycle pulse when hi/lo have just been updated

Behaviour:
- Combinational ops (res), zero latency, independent of the sequencer. Shift amount sa = a[log2(WIDTH)-1:0].
  - 0: a+b
  - 1: a-b
  - 2: a&b
  - 3: a|b
  - 4: signed a<b, zero-extended
  - 5: b<<LUI_SHIFT
  - 6: a^b
  - 7: unsigned a<b
  - 8: b<<sa
  - 9: b>>sa (logical)
  - 10: b>>>sa (arithmetic)
  - 11: ~(a|b)
  - 12..15: res = 0
- Wrap-around: add/sub wrap modulo 2^WIDTH. No overflow flag.
- isZero always reflects the current res.
- Sequencer FSM: IDLE -> RUN -> FIN -> IDLE.
- IDLE, on start=1 and func in 12..15 at a clk edge:
  - Latch |a|, |b| and the result-sign flags. Signed magnitude applies only for func 12 (MULT) and 14 (DIV); unsigned otherwise.
  - Load counter = WIDTH-1. Go to RUN. busy=1 from this edge.
- IDLE, on start=1 with func 0..11: ignored.
- RUN: one iteration per cycle.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
  - After the counter==0 iteration, go to FIN. RUN lasts exactly WIDTH cycles.
- FIN: one cycle.
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo at the FIN->IDLE edge. At that edge busy falls and done rises for exactly one cycle.
- Latency: start sampled at edge E0; done=1 and hi/lo valid in the cycle after edge E0+WIDTH+1.
- start while busy=1: ignored; the operation in flight is unaffected. start in the done cycle launches a new operation normally.
- Divide by zero: hi = dividend a (original, unsigned view), lo = all ones. No trap, normal latency.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- hi/lo hold their values until the next FIN.
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - hi=0, lo=0, busy=0, done=0.
  - FSM to IDLE, counter=0. Any operation in flight is discarded.
- res/isZero have no reset dependence.

Test Plan:
- WIDTH=32, func=1, a=5, b=5 -> res=0, isZero=1. Same inputs with func=10, a=4, b=0x80000000 -> res=0xF8000000.
- MULT a=0xFFFFFFFE (-2), b=3, start pulsed 1 cycle -> busy high 33 cycles, done pulses once 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A start asserted during busy with different operands does not change the result.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU, assert rst_n=0 at RUN cycle 10 -> busy=0, hi=lo=0 immediately. After release, no done pulse occurs. A new MULTU 6*7 then gives lo=42, hi=0.
